// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator for the pixel-clock domain.
// Two counters walk the raster (h per pixel, v per line). Each enabled cycle
// the current counter values are presented on pixel_x/pixel_y. The matching
// sync and visible decodes go through a PIPE_DELAY-deep delay line, so they
// line up with downstream pixel-data latency.
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   When defined, adds pattern_en / pattern_rgb. This is an 8-bar colour
//   test pattern that is delay-matched to visible_area. When undefined, no
//   pattern logic exists.
//
// Ports:
//   clock        in   pixel clock
//   reset        in   synchronous, active-high reset (priority over enable)
//   enable       in   advance the raster when high; hold all state when low
//   pattern_en   in   (VGA_TEST_PATTERN_EN only) enable the colour bars
//   pattern_rgb  out  (VGA_TEST_PATTERN_EN only) R[11:8] G[7:4] B[3:0]
//   pixel_x      out  presented horizontal count, 0..H_TOTAL-1
//   pixel_y      out  presented vertical count, 0..V_TOTAL-1
//   line_start   out  pulse with pixel_x==0 on an enabled cycle
//   frame_start  out  pulse with pixel_x==0 and pixel_y==0 on an enabled cycle
//   hsync        out  horizontal sync, active level HSYNC_POL, PIPE_DELAY late
//   vsync        out  vertical sync, active level VSYNC_POL, PIPE_DELAY late
//   visible_area out  active-region flag, PIPE_DELAY late
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 10,
    parameter int PIPE_DELAY = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               pattern_en,
    output logic [11:0]        pattern_rgb,
`endif
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               visible_area
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [X_WIDTH-1:0] H_LAST    = X_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIDTH-1:0] H_VIS_END = X_WIDTH'(H_VISIBLE);
    localparam logic [X_WIDTH-1:0] HS_START  = X_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [X_WIDTH-1:0] HS_END    = X_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [Y_WIDTH-1:0] V_LAST    = Y_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] V_VIS_END = Y_WIDTH'(V_VISIBLE);
    localparam logic [Y_WIDTH-1:0] VS_START  = Y_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [Y_WIDTH-1:0] VS_END    = Y_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    // h/v hold the coordinate that the next enabled cycle presents.
    logic [X_WIDTH-1:0] h;
    logic [Y_WIDTH-1:0] v;

    // Decode of (h, v). It is registered into stage 0 together with pixel_x/y.
    // v only moves on the h wrap, so vsync is line-aligned automatically.
    logic hsync_d, vsync_d, visible_d;

    always_comb begin
        visible_d = (h < H_VIS_END) && (v < V_VIS_END);
        hsync_d   = ((h >= HS_START) && (h < HS_END)) ? HS_ON : ~HS_ON;
        vsync_d   = ((v >= VS_START) && (v < VS_END)) ? VS_ON : ~VS_ON;
    end

    // Stage 0 is aligned with pixel_x/pixel_y; stage PIPE_DELAY drives the ports.
    logic [PIPE_DELAY:0] hs_pipe, vs_pipe, vis_pipe;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  bar;
    logic [11:0] rgb_d;
    logic [11:0] rgb_pipe [PIPE_DELAY+1];

    // bar = (h*8)/H_VISIBLE, found by threshold compares instead of a divider.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(h) * 8 >= k * H_VISIBLE) bar = bar + 3'd1;
        end
        case (bar)
            3'd0:    rgb_d = 12'hFFF;
            3'd1:    rgb_d = 12'hFF0;
            3'd2:    rgb_d = 12'h0FF;
            3'd3:    rgb_d = 12'h0F0;
            3'd4:    rgb_d = 12'hF0F;
            3'd5:    rgb_d = 12'hF00;
            3'd6:    rgb_d = 12'h00F;
            default: rgb_d = 12'h000;
        endcase
        if (!(visible_d && pattern_en)) rgb_d = 12'h000;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= PIPE_DELAY; i++) rgb_pipe[i] <= 12'h000;
        end else if (enable) begin
            rgb_pipe[0] <= rgb_d;
            for (int i = 1; i <= PIPE_DELAY; i++) rgb_pipe[i] <= rgb_pipe[i-1];
        end
    end

    assign pattern_rgb = rgb_pipe[PIPE_DELAY];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            h           <= '0;
            v           <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            // NOTE: every delay-line stage is reset. Otherwise stale sync
            // pulses would drain out for PIPE_DELAY cycles after reset.
            hs_pipe     <= {(PIPE_DELAY+1){~HS_ON}};
            vs_pipe     <= {(PIPE_DELAY+1){~VS_ON}};
            vis_pipe    <= '0;
        end else if (enable) begin
            pixel_x     <= h;
            pixel_y     <= v;
            line_start  <= (h == '0);
            frame_start <= (h == '0) && (v == '0);

            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end

            hs_pipe[0]  <= hsync_d;
            vs_pipe[0]  <= vsync_d;
            vis_pipe[0] <= visible_d;
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                vis_pipe[i] <= vis_pipe[i-1];
            end
        end else begin
            // Strobes describe an enabled cycle only; everything else holds.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    assign hsync        = hs_pipe[PIPE_DELAY];
    assign vsync        = vs_pipe[PIPE_DELAY];
    assign visible_area = vis_pipe[PIPE_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Runs four generator instances side by side on shared clock, reset, enable
// and pattern_en:
//   d0 : small mode (H 8/2/3/2, V 4/1/2/1), PIPE_DELAY=0, active-low syncs
//   d3 : small mode, PIPE_DELAY=3, active-low syncs
//   dp : small mode, PIPE_DELAY=1, active-high syncs
//   db : default 640x480 mode, PIPE_DELAY=0
// The reference model only counts enabled cycles since reset. It derives
// every output from that count with div/mod arithmetic.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int hpol; int vpol; int d;
    } cfg_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        vis;
        logic [11:0] rgb;
    } exp_t;

    localparam cfg_t C0 = '{hv:8, hf:2, hs:3, hb:2, vv:4, vf:1, vs:2, vb:1, hpol:0, vpol:0, d:0};
    localparam cfg_t C3 = '{hv:8, hf:2, hs:3, hb:2, vv:4, vf:1, vs:2, vb:1, hpol:0, vpol:0, d:3};
    localparam cfg_t CP = '{hv:8, hf:2, hs:3, hb:2, vv:4, vf:1, vs:2, vb:1, hpol:1, vpol:1, d:1};
    localparam cfg_t CB = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, hpol:0, vpol:0, d:0};

    logic clk = 1'b0;
    logic reset, enable, pattern_en;

    logic [9:0] x0, y0, x3, y3, xp, yp, xb, yb;
    logic ls0, fs0, hs0, vs0, vis0;
    logic ls3, fs3, hs3, vs3, vis3;
    logic lsp, fsp, hsp, vsp, visp;
    logic lsb, fsb, hsb, vsb, visb;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] rgb0, rgb3, rgbp, rgbb;
`else
    wire  [11:0] rgb0 = 12'h000;
    wire  [11:0] rgb3 = 12'h000;
    wire  [11:0] rgbp = 12'h000;
    wire  [11:0] rgbb = 12'h000;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .HSYNC_POL(0), .VSYNC_POL(0), .PIPE_DELAY(0)) d0 (
        .clock(clk), .reset(reset), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_en(pattern_en), .pattern_rgb(rgb0),
`endif
        .pixel_x(x0), .pixel_y(y0), .line_start(ls0), .frame_start(fs0),
        .hsync(hs0), .vsync(vs0), .visible_area(vis0));

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .HSYNC_POL(0), .VSYNC_POL(0), .PIPE_DELAY(3)) d3 (
        .clock(clk), .reset(reset), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_en(pattern_en), .pattern_rgb(rgb3),
`endif
        .pixel_x(x3), .pixel_y(y3), .line_start(ls3), .frame_start(fs3),
        .hsync(hs3), .vsync(vs3), .visible_area(vis3));

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .HSYNC_POL(1), .VSYNC_POL(1), .PIPE_DELAY(1)) dp (
        .clock(clk), .reset(reset), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_en(pattern_en), .pattern_rgb(rgbp),
`endif
        .pixel_x(xp), .pixel_y(yp), .line_start(lsp), .frame_start(fsp),
        .hsync(hsp), .vsync(vsp), .visible_area(visp));

    vga_timing_gen db (
        .clock(clk), .reset(reset), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_en(pattern_en), .pattern_rgb(rgbb),
`endif
        .pixel_x(xb), .pixel_y(yb), .line_start(lsb), .frame_start(fsb),
        .hsync(hsb), .vsync(vsb), .visible_area(visb));

    // ---------------- reference model state ----------------
    int k       = 0;      // enabled cycles since reset
    bit last_en = 1'b0;   // previous edge was an enabled, non-reset edge
    bit pen_hist [16];    // pattern_en seen at each presented pixel index

    always @(posedge clk) begin
        if (reset) begin
            k       <= 0;
            last_en <= 1'b0;
        end else if (enable) begin
            pen_hist[k % 16] <= pattern_en;
            k       <= k + 1;
            last_en <= 1'b1;
        end else begin
            last_en <= 1'b0;
        end
    end

    function automatic logic [11:0] bar_colour(int b);
        logic [11:0] c;
        case (b)
            0: c = 12'hFFF;  1: c = 12'hFF0;  2: c = 12'h0FF;  3: c = 12'h0F0;
            4: c = 12'hF0F;  5: c = 12'hF00;  6: c = 12'h00F;  default: c = 12'h000;
        endcase
        return c;
    endfunction

    // The n-th enabled cycle (n = kk) presents raster index kk-1. The delayed
    // signals describe raster index kk-1-d; before that exists they are idle.
    function automatic exp_t model(cfg_t c, int kk, bit le);
        exp_t e;
        int ht, vt, p, q, qx, qy;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        e  = '0;
        p  = (kk == 0) ? 0 : kk - 1;
        e.x  = 10'(p % ht);
        e.y  = 10'((p / ht) % vt);
        e.ls = le && (p % ht == 0);
        e.fs = le && (p % (ht * vt) == 0);
        q = kk - 1 - c.d;
        if (q < 0) begin
            e.hs  = (c.hpol == 0);
            e.vs  = (c.vpol == 0);
            e.vis = 1'b0;
            e.rgb = 12'h000;
        end else begin
            qx = q % ht;
            qy = (q / ht) % vt;
            e.vis = (qx < c.hv) && (qy < c.vv);
            e.hs  = (qx >= c.hv + c.hf && qx < c.hv + c.hf + c.hs) ? (c.hpol != 0) : (c.hpol == 0);
            e.vs  = (qy >= c.vv + c.vf && qy < c.vv + c.vf + c.vs) ? (c.vpol != 0) : (c.vpol == 0);
            e.rgb = (e.vis && pen_hist[q % 16]) ? bar_colour(qx * 8 / c.hv) : 12'h000;
        end
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cmp(string t, exp_t e, logic [9:0] x, logic [9:0] y, logic ls, logic fs,
                       logic hs, logic vs, logic vis, logic [11:0] rgb);
        check({t, ".pixel_x"}, x, e.x);
        check({t, ".pixel_y"}, y, e.y);
        check({t, ".line_start"}, ls, e.ls);
        check({t, ".frame_start"}, fs, e.fs);
        check({t, ".hsync"}, hs, e.hs);
        check({t, ".vsync"}, vs, e.vs);
        check({t, ".visible_area"}, vis, e.vis);
`ifdef VGA_TEST_PATTERN_EN
        check({t, ".pattern_rgb"}, rgb, e.rgb);
`else
        if (rgb !== 12'h000) check({t, ".rgb_tie"}, rgb, 12'h000);
`endif
    endtask

    // The single compare process runs on every falling edge once reset has
    // been seen.
    bit checking = 1'b0;
    always @(negedge clk) begin
        if (checking) begin
            cmp("d0", model(C0, k, last_en), x0, y0, ls0, fs0, hs0, vs0, vis0, rgb0);
            cmp("d3", model(C3, k, last_en), x3, y3, ls3, fs3, hs3, vs3, vis3, rgb3);
            cmp("dp", model(CP, k, last_en), xp, yp, lsp, fsp, hsp, vsp, visp, rgbp);
            cmp("db", model(CB, k, last_en), xb, yb, lsb, fsb, hsb, vsb, visb, rgbb);
        end
    end

    // ---------------- stimulus helpers (drive on falling edges) ----------------
    task automatic wait_fs(int budget);
        int n = 0;
        while (!fs0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_frame_start_in_budget", fs0, 1'b1);
    endtask

    task automatic wait_xy(int tx, int ty, int budget);
        int n = 0;
        while (!(x0 == 10'(tx) && y0 == 10'(ty)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_xy_in_budget", (x0 == 10'(tx) && y0 == 10'(ty)), 1'b1);
    endtask

    task automatic wait_big_x(int tx, int budget);
        int n = 0;
        while (xb != 10'(tx) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_big_x_in_budget", xb, 10'(tx));
    endtask

    // Call on a frame_start cycle. Counts one full frame of d0, up to the next pulse.
    task automatic measure_frame(output int period, output int vis_c, output int hsl_c,
                                 output int vsl_c, output int ls_c, output int vis3_c,
                                 output int hsp_c);
        period = 0; vis_c = 0; hsl_c = 0; vsl_c = 0; ls_c = 0; vis3_c = 0; hsp_c = 0;
        do begin
            vis_c  += int'(vis0);
            hsl_c  += int'(!hs0);
            vsl_c  += int'(!vs0);
            ls_c   += int'(ls0);
            vis3_c += int'(vis3);
            hsp_c  += int'(hsp);
            period++;
            @(negedge clk);
        end while (!fs0 && period < 500);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int period, vis_c, hsl_c, vsl_c, ls_c, vis3_c, hsp_c, stall_left;
        bit stalled;

        reset = 1'b1; enable = 1'b0; pattern_en = 1'b1;
        @(negedge clk);
        checking = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state: syncs idle, nothing visible.
        check("rst_pixel_x", x0, 0);
        check("rst_hsync_low_pol", hs0, 1);
        check("rst_vsync_low_pol", vs0, 1);
        check("rst_visible", vis0, 0);
        check("rst_frame_start", fs0, 0);
        check("rst_hsync_high_pol", hsp, 0);
        check("rst_vsync_high_pol", vsp, 0);
        check("rst_hsync_delayed", hs3, 1);

        // First enabled cycle presents (0,0) with both strobes.
        reset = 1'b0; enable = 1'b1;
        @(negedge clk);
        check("first_frame_start", fs0, 1);
        check("first_line_start", ls0, 1);
        check("first_pixel_y", y0, 0);

        // Two frames of free running; measure the second one.
        measure_frame(period, vis_c, hsl_c, vsl_c, ls_c, vis3_c, hsp_c);
        measure_frame(period, vis_c, hsl_c, vsl_c, ls_c, vis3_c, hsp_c);
        check("frame_period", period, 120);
        check("visible_per_frame", vis_c, 32);
        check("hsync_low_per_frame", hsl_c, 24);
        check("vsync_low_per_frame", vsl_c, 30);
        check("lines_per_frame", ls_c, 8);
        check("visible_per_frame_delay3", vis3_c, 32);
        check("hsync_high_per_frame_pol1", hsp_c, 24);

        // Stall 5 cycles at (6,2); the frame stretches to 125 cycles.
        wait_fs(10);
        period = 0; stalled = 1'b0; stall_left = 0;
        do begin
            period++;
            @(negedge clk);
            if (stall_left > 0) begin
                check("stall_pixel_frozen", x0, 6);
                stall_left--;
                if (stall_left == 0) enable = 1'b1;
            end else if (!stalled && x0 == 10'd6 && y0 == 10'd2) begin
                enable = 1'b0;
                stall_left = 5;
                stalled = 1'b1;
            end
        end while (!fs0 && period < 500);
        check("stall_happened", stalled, 1);
        check("stalled_frame_period", period, 125);

        // Reset inside both sync pulses.
        wait_xy(11, 6, 300);
        check("pre_reset_hsync_active", hs0, 0);
        check("pre_reset_vsync_active", vs0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_hsync", hs0, 1);
        check("mid_reset_vsync", vs0, 1);
        check("mid_reset_visible", vis0, 0);
        check("mid_reset_x", x0, 0);
        check("mid_reset_y", y0, 0);
        check("mid_reset_hsync_pol1", hsp, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_frame_start", fs0, 1);
        check("post_reset_x", x0, 0);

        // Random enable / occasional reset / pattern_en, checked by the model.
        for (int i = 0; i < 800; i++) begin
            enable     = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 39) == 0) pattern_en = ~pattern_en;
            @(negedge clk);
        end
        reset = 1'b0; enable = 1'b1;
        repeat (40) @(negedge clk);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars on the first line of the 640x480 instance.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; pattern_en = 1'b1;
        @(negedge clk);
        check("bar_x0", rgbb, 12'hFFF);
        wait_big_x(79, 900);   check("bar_x79", rgbb, 12'hFFF);
        wait_big_x(80, 900);   check("bar_x80", rgbb, 12'hFF0);
        wait_big_x(159, 900);  check("bar_x159", rgbb, 12'hFF0);
        wait_big_x(160, 900);  check("bar_x160", rgbb, 12'h0FF);
        wait_big_x(560, 900);  check("bar_x560", rgbb, 12'h000);
        wait_big_x(639, 900);  check("bar_x639", rgbb, 12'h000);
        wait_big_x(700, 900);  check("blank_x700", rgbb, 12'h000);
        pattern_en = 1'b0;
        wait_big_x(0, 900);
        wait_big_x(40, 900);   check("pattern_off_x40", rgbb, 12'h000);
        repeat (20) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, the next generation of the fixed-mode `vga` timing block in msgpu. All horizontal and vertical timings, sync polarities and the output pipeline delay are set by parameters. It produces pixel coordinates, frame and line strobes, and sync/visible signals delayed so they line up with downstream pixel-data latency. It sits in the pixel-clock domain between the PLL and the framebuffer/colour pipeline.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
X_WIDTH, 10, width of h counter / pixel_x; must hold H_TOTAL-1
Y_WIDTH, 10, width of v counter / pixel_y; must hold V_TOTAL-1
PIPE_DELAY, 0, extra cycles hsync/vsync/visible lag pixel_x/pixel_y (0..7)

Ports:
clock  in  1  pixel clock
reset  in  1  synchronous, active-high reset
enable  in  1  advance raster when high; hold all state when low
pixel_x  out  X_WIDTH  current horizontal count (0..H_TOTAL-1)
pixel_y  out  Y_WIDTH  current vertical count (0..V_TOTAL-1)
line_start  out  1  one-cycle pulse when pixel_x==0 and enable
frame_start  out  1  one-cycle pulse when pixel_x==0, pixel_y==0 and enable
hsync  out  1  horizontal sync, polarity HSYNC_POL, delayed PIPE_DELAY
vsync  out  1  vertical sync, polarity VSYNC_POL, delayed PIPE_DELAY
visible_area  out  1  high in the active region, delayed PIPE_DELAY

Behaviour:
- Clock is `clock`; reset is `reset`, synchronous, active-high. Both are fixed.
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined the same way.
- Counters: h increments every enabled cycle and wraps from H_TOTAL-1 to 0. v increments only on an h wrap and wraps from V_TOTAL-1 to 0.
- pixel_x/pixel_y are registered counter values.
- Decode relative to the counter values:
  - visible = (h < H_VISIBLE) && (v < V_VISIBLE)
  - hsync active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC
  - vsync active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC
  - vsync changes together with the h wrap (line-aligned).
- All outputs are registered, glitch-free and driven from flops only.
- With PIPE_DELAY=0, hsync/vsync/visible_area describe the same (pixel_x, pixel_y) presented in that cycle.
- With PIPE_DELAY=N, they describe the coordinate presented N cycles earlier. The delay line shifts only when enable is high.
- line_start/frame_start are always aligned with pixel_x/pixel_y (not delayed).
- Reset values:
  - counters 0
  - pixel_x=0, pixel_y=0
  - visible_area=0, line_start=0, frame_start=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - every delay-line stage cleared to its inactive level
- First enabled cycle after reset: pixel 0,0 is presented with frame_start=1 and line_start=1.
- enable low: counters, delay line and coordinate/sync outputs hold their values; line_start and frame_start are forced to 0.
- Reset asserted mid-frame: next cycle is in the reset state. No partial line completes.
- Reset takes priority over enable.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: adds input `pattern_en` (1 bit) and output `pattern_rgb` (12 bits, R[11:8] G[7:4] B[3:0]).
  - The visible width is split into 8 equal bars; bar index = (pixel_x*8)/H_VISIBLE.
  - Bar colours in order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - pattern_rgb is registered and delay-matched to visible_area.
  - It is 000 when visible_area=0 or pattern_en=0, and 000 at reset.
- Undefined: both ports are absent and no pattern logic is synthesised.

Test Plan:
1. Small mode (H 8/2/3/2 → H_TOTAL=15; V 4/1/2/1 → V_TOTAL=8), PIPE_DELAY=0, polarities 0: reset then enable=1 for 2 frames → frame_start period exactly 120 cycles; hsync low for h=10..12; vsync low for v=5..6; visible_area high 32 cycles per frame.
2. Same mode, PIPE_DELAY=3 → hsync/vsync/visible_area waveforms identical to scenario 1 but shifted 3 cycles; pixel_x/line_start unshifted.
3. Toggle enable low for 5 cycles at h=6,v=2 → all outputs frozen, line_start=0; resumes at h=7 with no lost or duplicated pixel; frame period becomes 125 cycles.
4. Assert reset at h=11,v=6 (inside both syncs) → next cycle hsync=1, vsync=1, visible_area=0, pixel_x=0, pixel_y=0; first enabled cycle gives frame_start=1.
5. HSYNC_POL=1, VSYNC_POL=1 → syncs idle 0, pulse high over the same ranges; reset value 0.
6. VGA_TEST_PATTERN_EN defined, default 640x480, pattern_en=1 → pattern_rgb=FFF at x=0..79, FF0 at x=80..159, 000 at x=560..639 and in blanking; pattern_en=0 → 000 everywhere.
